// File: rtl/apple1_pia_bus.sv
// Apple-1 I/O glue: RAM strobes, CPU read mux and a 4-byte keyboard/display
// register window backed by a keyboard FIFO and a display FIFO.
module apple1_pia_bus #(
    parameter logic [15:0] BASE_ADDR = 16'hD010,
    parameter int unsigned KBD_DEPTH = 4,
    parameter int unsigned DSP_DEPTH = 8
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        cpu_clken,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic [7:0]  ram_dout,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic        io_cs,
    input  logic        kbd_valid,
    input  logic [6:0]  kbd_data,
    output logic        kbd_overflow,
    output logic        dsp_valid,
    output logic [6:0]  dsp_data,
    input  logic        dsp_ready
);

    localparam int unsigned KW = $clog2(KBD_DEPTH);
    localparam int unsigned DW = $clog2(DSP_DEPTH);
    localparam logic [KW:0] KBD_FULL_CNT = (KW+1)'(KBD_DEPTH);
    localparam logic [DW:0] DSP_FULL_CNT = (DW+1)'(DSP_DEPTH);

    logic [1:0]    offset;
    logic          qual_rd;
    logic          qual_wr;
    logic          unused_bits;

    logic [6:0]    kbd_mem [KBD_DEPTH];
    logic [KW-1:0] kbd_wp;
    logic [KW-1:0] kbd_rp;
    logic [KW:0]   kbd_cnt;
    logic          kbd_full;
    logic          kbd_empty;
    logic          kbd_push;
    logic          kbd_pop;

    logic [6:0]    dsp_mem [DSP_DEPTH];
    logic [DW-1:0] dsp_wp;
    logic [DW-1:0] dsp_rp;
    logic [DW:0]   dsp_cnt;
    logic          dsp_full;
    logic          dsp_empty;
    logic          dsp_push;
    logic          dsp_pop;
    logic          dsp_flush;

    assign offset      = addr[1:0];
    assign io_cs       = (addr[15:2] == BASE_ADDR[15:2]);
    assign ram_rd      = ~io_cs;
    assign ram_wr      = we & ~io_cs;
    assign qual_rd     = cpu_clken & io_cs & ~we;
    assign qual_wr     = cpu_clken & io_cs & we;
    assign unused_bits = cpu_dout[7];

    assign kbd_full  = (kbd_cnt == KBD_FULL_CNT);
    assign kbd_empty = (kbd_cnt == '0);
    assign kbd_push  = kbd_valid & ~kbd_full;
    assign kbd_pop   = qual_rd & (offset == 2'd0) & ~kbd_empty;

    assign dsp_full  = (dsp_cnt == DSP_FULL_CNT);
    assign dsp_empty = (dsp_cnt == '0);
    assign dsp_valid = ~dsp_empty;
    assign dsp_data  = dsp_mem[dsp_rp];
    assign dsp_push  = qual_wr & (offset == 2'd2) & ~dsp_full;
    assign dsp_flush = qual_wr & (offset == 2'd3) & cpu_dout[0];
    assign dsp_pop   = dsp_valid & dsp_ready;

    // CPU read data: register window or RAM, zero latency
    always_comb begin
        cpu_din = ram_dout;
        if (io_cs) begin
            unique case (offset)
                2'd0:    cpu_din = kbd_empty ? 8'h80 : {1'b1, kbd_mem[kbd_rp]};
                2'd1:    cpu_din = {~kbd_empty, kbd_overflow, 6'b0};
                2'd2:    cpu_din = {dsp_full, 7'b0};
                default: cpu_din = {dsp_full, dsp_empty, 6'b0};
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (kbd_push) kbd_mem[kbd_wp] <= kbd_data;
        if (dsp_push) dsp_mem[dsp_wp] <= cpu_dout[6:0];
    end

    // Keyboard FIFO; a drop is judged on the pre-edge full state
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            kbd_wp       <= '0;
            kbd_rp       <= '0;
            kbd_cnt      <= '0;
            kbd_overflow <= 1'b0;
        end else begin
            if (kbd_push) kbd_wp <= kbd_wp + KW'(1);
            if (kbd_pop)  kbd_rp <= kbd_rp + KW'(1);
            unique case ({kbd_push, kbd_pop})
                2'b10:   kbd_cnt <= kbd_cnt + (KW+1)'(1);
                2'b01:   kbd_cnt <= kbd_cnt - (KW+1)'(1);
                default: kbd_cnt <= kbd_cnt;
            endcase
            if (kbd_valid & kbd_full)
                kbd_overflow <= 1'b1;
            else if (qual_rd & (offset == 2'd1))
                kbd_overflow <= 1'b0;
        end
    end

    // Display FIFO; flush overrides a same-cycle pop
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            dsp_wp  <= '0;
            dsp_rp  <= '0;
            dsp_cnt <= '0;
        end else if (dsp_flush) begin
            dsp_wp  <= '0;
            dsp_rp  <= '0;
            dsp_cnt <= '0;
        end else begin
            if (dsp_push) dsp_wp <= dsp_wp + DW'(1);
            if (dsp_pop)  dsp_rp <= dsp_rp + DW'(1);
            unique case ({dsp_push, dsp_pop})
                2'b10:   dsp_cnt <= dsp_cnt + (DW+1)'(1);
                2'b01:   dsp_cnt <= dsp_cnt - (DW+1)'(1);
                default: dsp_cnt <= dsp_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_apple1_pia_bus.sv
// Bench for apple1_pia_bus: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_apple1_pia_bus;

    localparam logic [15:0] BASE = 16'hD010;
    localparam int KD = 4;
    localparam int DD = 8;

    logic        sys_clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_clken = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic        we = 1'b0;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  cpu_din;
    logic [7:0]  ram_dout = 8'h00;
    logic        ram_rd;
    logic        ram_wr;
    logic        io_cs;
    logic        kbd_valid = 1'b0;
    logic [6:0]  kbd_data = 7'h00;
    logic        kbd_overflow;
    logic        dsp_valid;
    logic [6:0]  dsp_data;
    logic        dsp_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    apple1_pia_bus #(.BASE_ADDR(BASE), .KBD_DEPTH(KD), .DSP_DEPTH(DD)) dut (
        .sys_clock(sys_clock), .reset(reset), .cpu_clken(cpu_clken),
        .addr(addr), .we(we), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .ram_dout(ram_dout), .ram_rd(ram_rd), .ram_wr(ram_wr), .io_cs(io_cs),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_overflow(kbd_overflow),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: plain queues for the two FIFOs
    logic [6:0] kq[$];
    logic [6:0] dq[$];
    bit         ovf;
    bit         m_qual;
    bit         m_kfull;
    bit         m_dfull;
    int         m_off;

    function automatic bit in_win(input logic [15:0] a);
        return (a >= BASE) && (a < BASE + 16'd4);
    endfunction

    function automatic logic [7:0] exp_din();
        if (!in_win(addr)) return ram_dout;
        case (int'(addr - BASE))
            0:       return (kq.size() > 0) ? {1'b1, kq[0]} : 8'h80;
            1:       return {(kq.size() > 0), ovf, 6'b0};
            2:       return {(dq.size() == DD), 7'b0};
            default: return {(dq.size() == DD), (dq.size() == 0), 6'b0};
        endcase
    endfunction

    always @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            kq.delete();
            dq.delete();
            ovf = 1'b0;
        end else begin
            m_qual  = cpu_clken && in_win(addr);
            m_off   = int'(addr - BASE);
            m_kfull = (kq.size() == KD);
            m_dfull = (dq.size() == DD);
            if (m_qual && !we && m_off == 0 && kq.size() > 0) void'(kq.pop_front());
            if (m_qual && !we && m_off == 1) ovf = 1'b0;
            if (kbd_valid) begin
                if (m_kfull) ovf = 1'b1;
                else kq.push_back(kbd_data);
            end
            if (m_qual && we && m_off == 3 && cpu_dout[0]) begin
                dq.delete();
            end else begin
                if (dq.size() > 0 && dsp_ready) void'(dq.pop_front());
                if (m_qual && we && m_off == 2 && !m_dfull) dq.push_back(cpu_dout[6:0]);
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge sys_clock) begin
        chk("io_cs", {7'b0, io_cs}, {7'b0, in_win(addr)});
        chk("ram_rd", {7'b0, ram_rd}, {7'b0, !in_win(addr)});
        chk("ram_wr", {7'b0, ram_wr}, {7'b0, we && !in_win(addr)});
        chk("cpu_din", cpu_din, exp_din());
        chk("kbd_overflow", {7'b0, kbd_overflow}, {7'b0, ovf});
        chk("dsp_valid", {7'b0, dsp_valid}, {7'b0, dq.size() > 0});
        if (dq.size() > 0) chk("dsp_data", {1'b0, dsp_data}, {1'b0, dq[0]});
    end

    logic [6:0] outq[$];
    bit         collect = 1'b0;
    always @(negedge sys_clock)
        if (collect && dsp_valid && dsp_ready) outq.push_back(dsp_data);

    task automatic cyc(input logic cen, input logic [15:0] a, input logic w,
                       input logic [7:0] d, input logic kv, input logic [6:0] kd);
        @(posedge sys_clock);
        #1;
        cpu_clken = cen;
        addr      = a;
        we        = w;
        cpu_dout  = d;
        ram_dout  = a[7:0] ^ 8'h3C;
        kbd_valid = kv;
        kbd_data  = kd;
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 7'h00);
    endtask

    task automatic rd(input logic [15:0] a, input string nm, input logic [7:0] exp);
        cyc(1'b1, a, 1'b0, 8'h00, 1'b0, 7'h00);
        #2 chk(nm, cpu_din, exp);
    endtask

    task automatic key(input logic [6:0] k);
        cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, k);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge sys_clock);
        #1 reset = 1'b0;

        // Reset state and basic decode
        rd(16'hD011, "rst_kbdcr", 8'h00);
        rd(16'hD010, "rst_kbd_empty", 8'h80);
        rd(16'h1234, "ram_read", 8'h08);
        chk("ram_rd_1234", {7'b0, ram_rd}, 8'h01);

        // Two keys, read back in order
        key(7'h41);
        key(7'h42);
        rd(16'hD011, "kbd_avail", 8'h80);
        rd(16'hD010, "kbd_A", 8'hC1);
        rd(16'hD010, "kbd_B", 8'hC2);
        rd(16'hD011, "kbd_drained", 8'h00);

        // Overflow on the fifth key
        for (int i = 0; i < 5; i++) key(7'(8'h31 + i));
        rd(16'hD011, "kbd_ovf_set", 8'hC0);
        for (int i = 0; i < 4; i++) rd(16'hD010, "kbd_ovf_order", 8'(8'hB1 + i));
        rd(16'hD011, "kbd_ovf_cleared", 8'h00);

        // Key arriving while full and popped in the same cycle is still dropped
        for (int i = 0; i < 4; i++) key(7'(8'h61 + i));
        cyc(1'b1, 16'hD010, 1'b0, 8'h00, 1'b1, 7'h65);
        #2 chk("kbd_pop_and_drop", cpu_din, 8'hE1);
        rd(16'hD011, "kbd_drop_ovf", 8'hC0);
        for (int i = 0; i < 3; i++) rd(16'hD010, "kbd_after_drop", 8'(8'hE2 + i));
        rd(16'hD011, "kbd_drop_empty", 8'h00);

        // Overflow set wins over a same-cycle clear
        for (int i = 0; i < 4; i++) key(7'(8'h71 + i));
        cyc(1'b1, 16'hD011, 1'b0, 8'h00, 1'b1, 7'h75);
        #2 chk("ovf_clr_set_pre", cpu_din, 8'h80);
        rd(16'hD011, "ovf_set_wins", 8'hC0);
        for (int i = 0; i < 4; i++) rd(16'hD010, "kbd_drain", 8'(8'hF1 + i));

        // Writes to offsets 0 and 1 are ignored
        cyc(1'b1, 16'hD010, 1'b1, 8'hFF, 1'b0, 7'h00);
        cyc(1'b1, 16'hD011, 1'b1, 8'hFF, 1'b0, 7'h00);
        rd(16'hD011, "wr_ro_ignored", 8'h00);

        // Fill display FIFO with the display stalled
        dsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 16'hD012, 1'b1, 8'(8'hC1 + i), 1'b0, 7'h00);
            #2 chk("dsp_wr_no_ram_wr", {7'b0, ram_wr}, 8'h00);
        end
        rd(16'hD012, "dsp_full_bit", 8'h80);
        cyc(1'b1, 16'hD012, 1'b1, 8'h5A, 1'b0, 7'h00);
        rd(16'hD013, "dspcr_full", 8'h80);

        // Drain: exactly 8 chars, one per cycle, in order
        @(posedge sys_clock);
        #1 dsp_ready = 1'b1;
        collect = 1'b1;
        cpu_clken = 1'b0;
        for (int i = 0; i < 8; i++) idle();
        #2 chk("dsp_drained_valid", {7'b0, dsp_valid}, 8'h00);
        chk("dsp_out_count", 8'(outq.size()), 8'd8);
        for (int i = 0; i < 8; i++)
            if (i < outq.size()) chk("dsp_out_order", {1'b0, outq[i]}, 8'(8'h41 + i));
        collect = 1'b0;

        // Flush with three queued
        dsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'hD012, 1'b1, 8'(8'h51 + i), 1'b0, 7'h00);
        cyc(1'b1, 16'hD013, 1'b1, 8'h01, 1'b0, 7'h00);
        rd(16'hD013, "dspcr_flushed", 8'h40);
        chk("dsp_valid_flushed", {7'b0, dsp_valid}, 8'h00);

        // Flush while the display is popping
        dsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) cyc(1'b1, 16'hD012, 1'b1, 8'(8'h61 + i), 1'b0, 7'h00);
        cyc(1'b1, 16'hD013, 1'b1, 8'h01, 1'b0, 7'h00);
        rd(16'hD013, "flush_over_pop", 8'h40);

        // Reset mid-burst with both FIFOs populated
        dsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) key(7'(8'h21 + i));
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'hD012, 1'b1, 8'(8'h31 + i), 1'b0, 7'h00);
        cyc(1'b0, 16'hD011, 1'b0, 8'h00, 1'b0, 7'h00);
        #2 chk("pre_reset_ovf", {7'b0, kbd_overflow}, 8'h01);
        reset = 1'b1;
        #1 chk("rst_ovf", {7'b0, kbd_overflow}, 8'h00);
        chk("rst_dsp_valid", {7'b0, dsp_valid}, 8'h00);
        chk("rst_kbdcr_async", cpu_din, 8'h00);
        addr = 16'hD013;
        #1 chk("rst_dspcr_async", cpu_din, 8'h40);
        @(posedge sys_clock);
        #1 reset = 1'b0;

        // Unqualified writes: no push, never a RAM write
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 16'(BASE + i), 1'b1, 8'h41, 1'b0, 7'h00);
            #2 chk("noclken_ram_wr", {7'b0, ram_wr}, 8'h00);
        end
        rd(16'hD013, "noclken_no_push", 8'h40);
        chk("noclken_dsp_valid", {7'b0, dsp_valid}, 8'h00);
        cyc(1'b1, 16'h2000, 1'b1, 8'h00, 1'b0, 7'h00);
        #2 chk("ram_wr_outside", {7'b0, ram_wr}, 8'h01);

        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
